sprite_plotter: RTL and testbench
=================================

# sprite_plotter

Parametrised sprite drawing engine that turns one start request into a raster stream of pixel writes for the VGA adapter. Supported operations:
- draw a sprite from a shared sprite ROM;
- erase a sprite footprint with the background colour;
- move a sprite atomically: erase the old position, then draw at the new one.

It sits between the game control FSMs (player, coins, screens) and the VGA adapter's x/y/colour/plot port. It generalises the fixed single-object animation path to any sprite count, sprite size, screen size and colour depth, and adds transparency and screen-edge clipping.

## Interface
Parameters:
- X_W, 8, screen x coordinate width
- Y_W, 7, screen y coordinate width
- COLOUR_W, 9, pixel colour width (3 bits per channel)
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- SPR_W, 8, sprite width in pixels
- SPR_H, 8, sprite height in pixels
- NUM_SPR, 4, number of sprites stored in the ROM
- TRANSPARENT, 9'h1FF, ROM colour that is never plotted
- BG_COLOUR, 9'h000, colour written by erase

Ports:
- clock  in  1  single system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- iStart  in  1  request strobe; sampled only in IDLE
- iMode  in  2  0 DRAW, 1 ERASE, 2 MOVE, 3 reserved (treated as DRAW)
- iSprite  in  clog2(NUM_SPR)  sprite index
- iX  in  X_W  top-left x of the target
- iY  in  Y_W  top-left y of the target
- oBusy  out  1  operation in progress
- oDone  out  1  one-cycle completion pulse
- oRomAddr  out  clog2(NUM_SPR*SPR_W*SPR_H)  sprite ROM address
- iRomData  in  COLOUR_W  ROM data, valid one cycle after the address
- oX  out  X_W  pixel x to the VGA adapter
- oY  out  Y_W  pixel y to the VGA adapter
- oColour  out  COLOUR_W  pixel colour
- oPlot  out  1  write enable to the VGA adapter

## Operation
- FSM states: IDLE, ERASE_RUN, DRAW_RUN, DONE.
- IDLE with iStart=1: latch iMode, iSprite, iX and iY, then branch:
  - DRAW goes to DRAW_RUN.
  - ERASE goes to ERASE_RUN at the request position.
  - MOVE goes to ERASE_RUN at the stored last position, then to DRAW_RUN at the request position.
  - MOVE with lastValid=0 behaves as DRAW.
- Pixel counters cx (0..SPR_W-1) and cy (0..SPR_H-1) scan in raster order. cx wraps to 0 and increments cy. When cy wraps, the run phase ends.
- ROM address = sprite*SPR_W*SPR_H + cy*SPR_W + cx, computed without truncation before the final width.
- Pixel coordinates: px = baseX + cx and py = baseY + cy, computed one bit wider than X_W and Y_W.
- A pixel is plotted only if px < SCREEN_W and py < SCREEN_H. Clipped pixels still consume their cycle.
- DRAW_RUN: a pixel is plotted only if iRomData != TRANSPARENT.
- ERASE_RUN: every in-screen pixel is plotted with BG_COLOUR. The ROM address is still driven and the data is ignored.
- On the end of DRAW_RUN for a DRAW or MOVE: lastX, lastY and lastValid=1 are updated. ERASE clears lastValid.
- iStart outside IDLE is ignored and not queued.
- Reset at any time, including mid-run:
  - FSM goes to IDLE and lastValid to 0.
  - All outputs go to 0: oX, oY, oColour, oPlot, oBusy, oDone and oRomAddr.

## Timing
- Cycle 0 is the edge that samples iStart=1 in IDLE. N = SPR_W*SPR_H.
- oBusy is high from cycle 1 until the DONE cycle, where it is low.
- Each phase presents addresses in cycles k..k+N-1. The outputs oX, oY, oColour and oPlot are registered and appear one cycle later, aligned with iRomData.
- DRAW and ERASE: pixel outputs in cycles 2..N+1; oDone=1 in cycle N+2, followed by IDLE. A new iStart is accepted in cycle N+2.
- MOVE: the DRAW_RUN addresses start right after the last erase address, with no bubble. Erase pixels occupy cycles 2..N+1, draw pixels cycles N+2..2N+1, and oDone is in cycle 2N+2.
- oPlot=0 on every cycle without a valid, unclipped, opaque pixel.

## Structure
- Package sprite_pkg holds:
  - the mode enum (MODE_DRAW, MODE_ERASE, MODE_MOVE);
  - the FSM state typedef;
  - default screen and colour constants shared with the VGA and map blocks.
- Sub-module sprite_scan_counter (cx/cy raster counter with start, enable and a last-pixel flag) is instantiated once and restarted per phase.
- The sprite ROM is external to this block.

## Test plan
- DRAW sprite 1 at (10,20) with a ROM pattern of colour = address and no transparency:
  - 64 plots in cycles 2..65, the first at (10,20) with colour 64 and the last at (17,27) with colour 127;
  - oDone in cycle 66.
- DRAW sprite 0 at (156,116):
  - only the 16 pixels with x ≤ 159 and y ≤ 119 are plotted;
  - oDone still occurs in cycle 66.
- ROM with all odd addresses = 9'h1FF: DRAW produces exactly 32 plots, and the skipped pixels have oPlot=0.
- DRAW at (2,2), then MOVE to (3,3):
  - 64 BG_COLOUR plots at (2..9,2..9), followed by 64 sprite plots at (3..10,3..10);
  - oDone in cycle 130.
- iStart pulsed in cycle 5 of a DRAW: ignored, and exactly one oDone occurs.
- reset asserted in cycle 30 of a MOVE: all outputs go to 0 immediately. A following MOVE with iX=40, iY=40 then behaves as DRAW, with the first plot at (40,40) in cycle 2.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and default screen/colour constants for the sprite engine.
package sprite_pkg;

  localparam int unsigned X_W_DEF      = 8;
  localparam int unsigned Y_W_DEF      = 7;
  localparam int unsigned COLOUR_W_DEF = 9;
  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;

  localparam logic [8:0] TRANSPARENT_DEF = 9'h1FF;
  localparam logic [8:0] BG_COLOUR_DEF   = 9'h000;

  typedef enum logic [1:0] {
    MODE_DRAW  = 2'd0,
    MODE_ERASE = 2'd1,
    MODE_MOVE  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ERASE_RUN = 2'd1,
    DRAW_RUN  = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster-order cx/cy counter over one sprite footprint.
module sprite_scan_counter #(
  parameter int unsigned SPR_W = 8,
  parameter int unsigned SPR_H = 8,
  localparam int unsigned CX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1,
  localparam int unsigned CY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            en,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last_c
);

  logic cx_wrap;

  // End-of-row and end-of-footprint flags.
  assign cx_wrap = (cx == CX_W'(SPR_W - 1));
  assign last_c  = cx_wrap && (cy == CY_W'(SPR_H - 1));

  // Restart on start, otherwise advance one pixel per enabled cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (start) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx_wrap) begin
        cx <= '0;
        cy <= last_c ? '0 : cy + CY_W'(1);
      end else begin
        cx <= cx + CX_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Sprite draw/erase/move engine producing a clipped pixel stream for the VGA adapter.
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int unsigned X_W      = X_W_DEF,
  parameter int unsigned Y_W      = Y_W_DEF,
  parameter int unsigned COLOUR_W = COLOUR_W_DEF,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned SPR_W    = 8,
  parameter int unsigned SPR_H    = 8,
  parameter int unsigned NUM_SPR  = 4,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = COLOUR_W'(TRANSPARENT_DEF),
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = COLOUR_W'(BG_COLOUR_DEF),
  localparam int unsigned SPR_IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
  localparam int unsigned ADDR_W    = (NUM_SPR * SPR_W * SPR_H > 1) ? $clog2(NUM_SPR * SPR_W * SPR_H) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iStart,
  input  logic [1:0]           iMode,
  input  logic [SPR_IDX_W-1:0] iSprite,
  input  logic [X_W-1:0]       iX,
  input  logic [Y_W-1:0]       iY,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [ADDR_W-1:0]    oRomAddr,
  input  logic [COLOUR_W-1:0]  iRomData,
  output logic [X_W-1:0]       oX,
  output logic [Y_W-1:0]       oY,
  output logic [COLOUR_W-1:0]  oColour,
  output logic                 oPlot
);

  localparam int unsigned PIX_N = SPR_W * SPR_H;
  localparam int unsigned CX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned CY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned PX_W  = X_W + 1;
  localparam int unsigned PY_W  = Y_W + 1;

  state_e state, next_state;

  logic [CX_W-1:0]      cx;
  logic [CY_W-1:0]      cy;
  logic                 scan_last_c;
  logic                 cnt_start, cnt_en;
  logic                 accept, to_draw, upd_last, clr_last;
  logic                 move_req, move_q;
  logic [SPR_IDX_W-1:0] spr_q;
  logic [X_W-1:0]       base_x, req_x, last_x;
  logic [Y_W-1:0]       base_y, req_y, last_y;
  logic                 last_valid;
  logic [PX_W-1:0]      px;
  logic [PY_W-1:0]      py;
  logic                 on_screen;
  logic                 running;

  sprite_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .start  (cnt_start),
    .en     (cnt_en),
    .cx     (cx),
    .cy     (cy),
    .last_c (scan_last_c)
  );

  // A move only erases when there is a previously drawn position to erase.
  assign move_req  = (iMode == MODE_MOVE) && last_valid;
  assign px        = PX_W'(base_x) + PX_W'(cx);
  assign py        = PY_W'(base_y) + PY_W'(cy);
  assign on_screen = (px < PX_W'(SCREEN_W)) && (py < PY_W'(SCREEN_H));
  assign running   = (state == ERASE_RUN) || (state == DRAW_RUN);

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and phase control.
  always_comb begin
    next_state = state;
    cnt_start  = 1'b0;
    cnt_en     = 1'b0;
    accept     = 1'b0;
    to_draw    = 1'b0;
    upd_last   = 1'b0;
    clr_last   = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          accept    = 1'b1;
          cnt_start = 1'b1;
          if ((iMode == MODE_ERASE) || move_req) next_state = ERASE_RUN;
          else                                   next_state = DRAW_RUN;
        end
      end
      ERASE_RUN: begin
        cnt_en = 1'b1;
        if (scan_last_c) begin
          if (move_q) begin
            next_state = DRAW_RUN;
            cnt_start  = 1'b1;
            to_draw    = 1'b1;
          end else begin
            next_state = DONE;
            clr_last   = 1'b1;
          end
        end
      end
      DRAW_RUN: begin
        cnt_en = 1'b1;
        if (scan_last_c) begin
          next_state = DONE;
          upd_last   = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, per-phase base position and last-drawn position tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spr_q      <= '0;
      move_q     <= 1'b0;
      req_x      <= '0;
      req_y      <= '0;
      base_x     <= '0;
      base_y     <= '0;
      last_x     <= '0;
      last_y     <= '0;
      last_valid <= 1'b0;
    end else begin
      if (accept) begin
        spr_q  <= iSprite;
        move_q <= move_req;
        req_x  <= iX;
        req_y  <= iY;
        base_x <= move_req ? last_x : iX;
        base_y <= move_req ? last_y : iY;
      end
      if (to_draw) begin
        base_x <= req_x;
        base_y <= req_y;
      end
      if (upd_last) begin
        last_x     <= base_x;
        last_y     <= base_y;
        last_valid <= 1'b1;
      end
      if (clr_last) last_valid <= 1'b0;
    end
  end

  // ROM address and status; raster order makes the address sequence contiguous from the sprite base.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oRomAddr <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      oBusy <= (next_state != IDLE);
      oDone <= (state == DONE);
      if (accept)       oRomAddr <= ADDR_W'(32'(iSprite) * PIX_N);
      else if (to_draw) oRomAddr <= ADDR_W'(32'(spr_q) * PIX_N);
      else if (cnt_en)  oRomAddr <= oRomAddr + ADDR_W'(1);
    end
  end

  // Pixel stage, aligned with the ROM data for the address of the current cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
    end else begin
      oPlot <= 1'b0;
      if (running) begin
        oX      <= px[X_W-1:0];
        oY      <= py[Y_W-1:0];
        oColour <= (state == ERASE_RUN) ? BG_COLOUR : iRomData;
        oPlot   <= on_screen && ((state == ERASE_RUN) || (iRomData != TRANSPARENT));
      end
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter with a combinational ROM model and plot recorder.
module tb_sprite_plotter;

  localparam int N = 64;
  localparam logic [1:0] M_DRAW  = 2'd0;
  localparam logic [1:0] M_ERASE = 2'd1;
  localparam logic [1:0] M_MOVE  = 2'd2;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [1:0] sprite;
  logic [7:0] x;
  logic [6:0] y;
  logic       busy, done, plot;
  logic [7:0] rom_addr;
  logic [8:0] rom_data, colour;
  logic [7:0] px;
  logic [6:0] py;
  logic [8:0] rom [256];

  int tests = 0;
  int fails = 0;
  int rec_n, exp_n;
  int rec_k [256], rec_x [256], rec_y [256], rec_c [256];
  int exp_k [256], exp_x [256], exp_y [256], exp_c [256];
  int done_cycle, done_cnt, busy_err, addr_c1;

  assign rom_data = rom[rom_addr];

  always #5 clock = ~clock;

  sprite_plotter dut (
    .clock    (clock),
    .reset    (reset),
    .iStart   (start),
    .iMode    (mode),
    .iSprite  (sprite),
    .iX       (x),
    .iY       (y),
    .oBusy    (busy),
    .oDone    (done),
    .oRomAddr (rom_addr),
    .iRomData (rom_data),
    .oX       (px),
    .oY       (py),
    .oColour  (colour),
    .oPlot    (plot)
  );

  task automatic check(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic load_rom(input bit odd_transparent);
    for (int a = 0; a < 256; a++)
      rom[a] = (odd_transparent && (a % 2 == 1)) ? 9'h1FF : 9'(a);
  endtask

  // Issue one request (cycle 0 = sampling edge) and record cycles 1..ncyc.
  task automatic run_op(input logic [1:0] m, input logic [1:0] s, input logic [7:0] ox,
                        input logic [6:0] oy, input int ncyc, input int pulse_at, input int rst_at);
    @(negedge clock);
    start = 1'b1; mode = m; sprite = s; x = ox; y = oy;
    @(posedge clock);
    rec_n = 0; done_cycle = -1; done_cnt = 0; busy_err = 0; addr_c1 = -1;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clock);
      start = (t == pulse_at);
      if (t == rst_at) begin
        reset = 1'b1;
        return;
      end
      if (t == 1) addr_c1 = int'(rom_addr);
      if (plot === 1'b1 && rec_n < 256) begin
        rec_k[rec_n] = t; rec_x[rec_n] = int'(px);
        rec_y[rec_n] = int'(py); rec_c[rec_n] = int'(colour);
        rec_n++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = t;
      end
      if (busy !== (done_cnt == 0)) busy_err++;
    end
  endtask

  // Expected plots of one phase whose pixel i lands in cycle c0+i.
  task automatic add_phase(input bit erase, input int bx, input int by, input int s, input int c0);
    int ax, ay, col;
    for (int i = 0; i < N; i++) begin
      ax = bx + i % 8;
      ay = by + i / 8;
      col = erase ? 0 : int'(rom[s * N + i]);
      if (ax < 160 && ay < 120 && (erase || col != 'h1FF) && exp_n < 256) begin
        exp_k[exp_n] = c0 + i; exp_x[exp_n] = ax; exp_y[exp_n] = ay; exp_c[exp_n] = col;
        exp_n++;
      end
    end
  endtask

  task automatic check_plots(input string tag);
    int bad, lim;
    bad = (rec_n > exp_n) ? rec_n - exp_n : exp_n - rec_n;
    lim = (rec_n < exp_n) ? rec_n : exp_n;
    for (int i = 0; i < lim; i++)
      if (rec_k[i] != exp_k[i] || rec_x[i] != exp_x[i] || rec_y[i] != exp_y[i] || rec_c[i] != exp_c[i])
        bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; sprite = '0; x = '0; y = '0;
    load_rom(1'b0);
    repeat (3) @(negedge clock);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_plot", int'(plot), 0);
    check("reset_addr", int'(rom_addr), 0);
    check("reset_xyc", int'({px, py, colour}), 0);
    @(negedge clock);
    reset = 1'b0;

    // Plain draw, colour = address.
    run_op(M_DRAW, 2'd1, 8'd10, 7'd20, 70, -1, -1);
    check("draw_addr_c1", addr_c1, 64);
    check("draw_count", rec_n, 64);
    check("draw_first_cycle", rec_k[0], 2);
    check("draw_first_x", rec_x[0], 10);
    check("draw_first_y", rec_y[0], 20);
    check("draw_first_col", rec_c[0], 64);
    check("draw_last_cycle", rec_k[63], 65);
    check("draw_last_xy", rec_x[63] * 1000 + rec_y[63], 17027);
    check("draw_last_col", rec_c[63], 127);
    check("draw_done_cycle", done_cycle, 66);
    check("draw_done_cnt", done_cnt, 1);
    check("draw_busy", busy_err, 0);
    exp_n = 0; add_phase(1'b0, 10, 20, 1, 2); check_plots("draw_plots");

    // Clipping at the bottom-right corner.
    run_op(M_DRAW, 2'd0, 8'd156, 7'd116, 70, -1, -1);
    check("clip_count", rec_n, 16);
    check("clip_first_xy", rec_x[0] * 1000 + rec_y[0], 156116);
    check("clip_last_cycle", rec_k[15], 29);
    check("clip_last_xy", rec_x[15] * 1000 + rec_y[15], 159119);
    check("clip_last_col", rec_c[15], 27);
    check("clip_done_cycle", done_cycle, 66);
    exp_n = 0; add_phase(1'b0, 156, 116, 0, 2); check_plots("clip_plots");

    // Transparency: odd addresses never plotted.
    load_rom(1'b1);
    run_op(M_DRAW, 2'd2, 8'd50, 7'd60, 70, -1, -1);
    check("transp_count", rec_n, 32);
    check("transp_first_col", rec_c[0], 128);
    check("transp_last_cycle", rec_k[31], 64);
    check("transp_last_xy", rec_x[31] * 1000 + rec_y[31], 56067);
    check("transp_last_col", rec_c[31], 190);
    check("transp_done_cycle", done_cycle, 66);
    exp_n = 0; add_phase(1'b0, 50, 60, 2, 2); check_plots("transp_plots");
    load_rom(1'b0);

    // Draw then move by (1,1).
    run_op(M_DRAW, 2'd3, 8'd2, 7'd2, 70, -1, -1);
    check("pre_move_done", done_cycle, 66);
    run_op(M_MOVE, 2'd3, 8'd3, 7'd3, 135, -1, -1);
    check("move_count", rec_n, 128);
    check("move_erase_first", rec_x[0] * 1000 + rec_y[0], 2002);
    check("move_erase_col", rec_c[0], 0);
    check("move_draw_first_cycle", rec_k[64], 66);
    check("move_draw_first_xy", rec_x[64] * 1000 + rec_y[64], 3003);
    check("move_draw_first_col", rec_c[64], 192);
    check("move_last_xy", rec_x[127] * 1000 + rec_y[127], 10010);
    check("move_done_cycle", done_cycle, 130);
    check("move_done_cnt", done_cnt, 1);
    check("move_busy", busy_err, 0);
    exp_n = 0; add_phase(1'b1, 2, 2, 3, 2); add_phase(1'b0, 3, 3, 3, 66); check_plots("move_plots");

    // Start strobe during a run is dropped.
    run_op(M_DRAW, 2'd1, 8'd30, 7'd30, 140, 5, -1);
    check("ignore_done_cnt", done_cnt, 1);
    check("ignore_done_cycle", done_cycle, 66);
    check("ignore_count", rec_n, 64);
    check("ignore_busy", busy_err, 0);

    // Erase, after which a move has nothing to erase.
    run_op(M_ERASE, 2'd0, 8'd5, 7'd5, 70, -1, -1);
    check("erase_done_cycle", done_cycle, 66);
    exp_n = 0; add_phase(1'b1, 5, 5, 0, 2); check_plots("erase_plots");
    run_op(M_MOVE, 2'd2, 8'd70, 7'd70, 135, -1, -1);
    check("move_after_erase_done", done_cycle, 66);
    check("move_after_erase_count", rec_n, 64);

    // Reset in the middle of a move.
    run_op(M_DRAW, 2'd1, 8'd100, 7'd50, 70, -1, -1);
    run_op(M_MOVE, 2'd1, 8'd60, 7'd50, 40, -1, 30);
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_plot", int'(plot), 0);
    check("midrst_addr", int'(rom_addr), 0);
    check("midrst_xyc", int'({px, py, colour}), 0);
    @(negedge clock);
    reset = 1'b0;
    run_op(M_MOVE, 2'd0, 8'd40, 7'd40, 135, -1, -1);
    check("post_rst_first_cycle", rec_k[0], 2);
    check("post_rst_first_xy", rec_x[0] * 1000 + rec_y[0], 40040);
    check("post_rst_first_col", rec_c[0], 0);
    check("post_rst_count", rec_n, 64);
    check("post_rst_done_cycle", done_cycle, 66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
